// File: rtl/shift_pkg.sv
// Shared constants and op encodings for the shift arbiter slice.
package shift_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } shift_op_e;

   // Output slot occupancy.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

endpackage

// File: rtl/shift_core.sv
// Combinational log shifter: LSL/LSR/ASR/ROR in SHAMT_W right-shift stages.
// LSL is done as a right shift of the bit-reversed operand, so every stage
// only needs a fill select: zero, sign, or the bits wrapping round.
module shift_core #(
   parameter int DATA_W  = shift_pkg::DATA_W,
   parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
   input  logic [1:0]         op,
   input  logic [DATA_W-1:0]  data,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [DATA_W-1:0]  result
);
   import shift_pkg::*;

   shift_op_e         op_e;
   logic              sign;
   logic [DATA_W-1:0] src;
   logic [DATA_W-1:0] rev_out;
   logic [DATA_W-1:0] last;

   assign op_e = shift_op_e'(op);
   assign sign = data[DATA_W-1];

   // Bit-reverse on the way in and out for LSL only.
   for (genvar i = 0; i < DATA_W; i++) begin : g_rev
      assign src[i]     = (op_e == SH_LSL) ? data[DATA_W-1-i] : data[i];
      assign rev_out[i] = last[DATA_W-1-i];
   end

   for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
      localparam int SH = 1 << s;
      logic [DATA_W-1:0] din;
      logic [DATA_W-1:0] dout;
      logic [SH-1:0]     fill;

      if (s == 0) begin : g_first
         assign din = src;
      end else begin : g_next
         assign din = g_stage[s-1].dout;
      end

      // Bits entering at the top of this stage.
      always_comb begin
         fill = '0;
         case (op_e)
            SH_ASR:  fill = {SH{sign}};
            SH_ROR:  fill = din[SH-1:0];
            default: fill = '0;
         endcase
      end

      assign dout = shamt[s] ? {fill, din[DATA_W-1:SH]} : din;
   end

   assign last   = g_stage[SHAMT_W-1].dout;
   assign result = (op_e == SH_LSL) ? rev_out : last;

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of one shared shifter, with a single
// registered result slot under valid/ready backpressure.
module shift_arbiter #(
   parameter int DATA_W  = shift_pkg::DATA_W,
   parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [1:0]         req0_op,
   input  logic [DATA_W-1:0]  req0_data,
   input  logic [SHAMT_W-1:0] req0_shamt,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [1:0]         req1_op,
   input  logic [DATA_W-1:0]  req1_data,
   input  logic [SHAMT_W-1:0] req1_shamt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               rsp_id
);
   import shift_pkg::*;

   slot_e              state;
   logic               last_grant;
   logic               can_accept;
   logic               grant0;
   logic               grant1;
   logic               accept;
   logic               sel_id;
   logic [1:0]         sel_op;
   logic [DATA_W-1:0]  sel_data;
   logic [SHAMT_W-1:0] sel_shamt;
   logic [DATA_W-1:0]  core_result;

   // Slot can take a new result when empty or being drained this cycle.
   assign can_accept = (state == SLOT_EMPTY) | rsp_ready;

   // Round robin: a lone valid always wins; on conflict the port that did
   // not win last time goes. Grants are mutually exclusive by construction.
   assign grant0 = req0_valid & (~req1_valid | last_grant);
   assign grant1 = req1_valid & (~req0_valid | ~last_grant);

   // Readies are held low for the whole time reset is asserted.
   assign req0_ready = rst_n & can_accept & grant0;
   assign req1_ready = rst_n & can_accept & grant1;
   assign accept     = req0_ready | req1_ready;

   // Payload mux ahead of the single shifter instance.
   assign sel_id    = grant1;
   assign sel_op    = sel_id ? req1_op    : req0_op;
   assign sel_data  = sel_id ? req1_data  : req0_data;
   assign sel_shamt = sel_id ? req1_shamt : req0_shamt;

   shift_core #(
      .DATA_W  (DATA_W),
      .SHAMT_W (SHAMT_W)
   ) u_core (
      .op     (sel_op),
      .data   (sel_data),
      .shamt  (sel_shamt),
      .result (core_result)
   );

   // Slot FSM: accept overwrites (even while draining), drain alone empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SLOT_EMPTY;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         last_grant <= 1'b1;
      end else if (accept) begin
         state      <= SLOT_FULL;
         rsp_data   <= core_result;
         rsp_id     <= sel_id;
         last_grant <= sel_id;
      end else if (rsp_ready) begin
         state      <= SLOT_EMPTY;
      end
   end

   assign rsp_valid = (state == SLOT_FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: op table plus arbitration/backpressure/reset sequences.
module tb_shift_arbiter;
   import shift_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_data, req1_data;
   logic [4:0]  req0_shamt, req1_shamt;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   shift_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_data  (req0_data),
      .req0_shamt (req0_shamt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_data  (req1_data),
      .req1_shamt (req1_shamt),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
      req0_valid = v; req0_op = op; req0_data = d; req0_shamt = sh;
   endtask

   task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
      req1_valid = v; req1_op = op; req1_data = d; req1_shamt = sh;
   endtask

   initial begin
      logic [31:0] lone_exp [4];
      lone_exp[0] = 32'h8000_0000;
      lone_exp[1] = 32'hC000_0000;
      lone_exp[2] = 32'hE000_0000;
      lone_exp[3] = 32'hF000_0000;

      vecs[0]  = '{SH_LSR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
      vecs[1]  = '{SH_LSL, 32'h0000_0001, 5'd31, 32'h8000_0000};
      vecs[2]  = '{SH_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000};
      vecs[3]  = '{SH_ASR, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
      vecs[4]  = '{SH_ASR, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
      vecs[5]  = '{SH_ROR, 32'h1234_5678, 5'd8,  32'h7812_3456};
      vecs[6]  = '{SH_LSR, 32'h8000_0000, 5'd31, 32'h0000_0001};
      vecs[7]  = '{SH_LSL, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0};
      vecs[8]  = '{SH_ROR, 32'h8000_0001, 5'd31, 32'h0000_0003};
      vecs[9]  = '{SH_ASR, 32'hF000_0000, 5'd0,  32'hF000_0000};
      vecs[10] = '{SH_LSR, 32'hDEAD_BEEF, 5'd16, 32'h0000_DEAD};
      vecs[11] = '{SH_ASR, 32'h4000_0000, 5'd30, 32'h0000_0001};
      vecs[12] = '{SH_LSL, 32'h1234_5678, 5'd16, 32'h5678_0000};

      set0(1'b0, SH_LSL, 32'h0, 5'd0);
      set1(1'b0, SH_LSL, 32'h0, 5'd0);
      rsp_ready = 1'b0;

      // Reset state, readies forced low even with requests pending.
      #12;
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", rsp_data, 32'd0);
      chk("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("reset_ready0", {31'b0, req0_ready}, 32'd0);
      chk("reset_ready1", {31'b0, req1_ready}, 32'd0);
      rst_n = 1'b1;

      // Fairness from reset: 0,1,0,1 with one result per cycle.
      rsp_ready = 1'b1;
      set0(1'b1, SH_LSL, 32'h0000_0001, 5'd1);
      set1(1'b1, SH_LSR, 32'h0000_0100, 5'd4);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_ready0", {31'b0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("fair_ready1", {31'b0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("fair_one_hot", {31'b0, req0_ready & req1_ready}, 32'd0);
         tick();
         chk("fair_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("fair_rsp_id", {31'b0, rsp_id}, (k % 2 == 1) ? 32'd1 : 32'd0);
         chk("fair_rsp_data", rsp_data, (k % 2 == 1) ? 32'h0000_0010 : 32'h0000_0002);
      end

      // Lone requester 1 wins every cycle even though it won last.
      req0_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         set1(1'b1, SH_ASR, 32'h8000_0000, 5'(k));
         #1;
         chk("lone_ready1", {31'b0, req1_ready}, 32'd1);
         chk("lone_ready0", {31'b0, req0_ready}, 32'd0);
         tick();
         chk("lone_rsp_id", {31'b0, rsp_id}, 32'd1);
         chk("lone_rsp_data", rsp_data, lone_exp[k]);
      end

      // Backpressure: slot full, consumer stalled for 3 cycles.
      rsp_ready = 1'b0;
      set0(1'b1, SH_LSL, 32'h0000_0001, 5'd1);
      set1(1'b1, SH_ROR, 32'h0000_0001, 5'd1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready0", {31'b0, req0_ready}, 32'd0);
         chk("bp_ready1", {31'b0, req1_ready}, 32'd0);
         tick();
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rsp_data", rsp_data, 32'hF000_0000);
         chk("bp_rsp_id", {31'b0, rsp_id}, 32'd1);
      end
      // Drain and accept together: no bubble.
      req0_valid = 1'b0;
      rsp_ready  = 1'b1;
      #1;
      chk("bp_release_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      chk("bp_overwrite_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_overwrite_id", {31'b0, rsp_id}, 32'd1);
      chk("bp_overwrite_data", rsp_data, 32'h8000_0000);

      // Op table, back to back on port 0.
      req1_valid = 1'b0;
      foreach (vecs[i]) begin
         set0(1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt);
         #1;
         chk("tbl_ready0", {31'b0, req0_ready}, 32'd1);
         tick();
         chk("tbl_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk($sformatf("tbl_data_%0d", i), rsp_data, vecs[i].exp);
         chk("tbl_rsp_id", {31'b0, rsp_id}, 32'd0);
      end
      // Drain with no accept: valid drops, data holds.
      req0_valid = 1'b0;
      #1;
      tick();
      chk("drain_valid", {31'b0, rsp_valid}, 32'd0);
      chk("drain_data_hold", rsp_data, 32'h5678_0000);

      // Single ASR, 1-cycle latency then slot empties.
      set0(1'b1, SH_ASR, 32'h8000_0000, 5'd4);
      #1;
      tick();
      chk("asr_valid", {31'b0, rsp_valid}, 32'd1);
      chk("asr_data", rsp_data, 32'hF800_0000);
      chk("asr_id", {31'b0, rsp_id}, 32'd0);
      req0_valid = 1'b0;
      tick();
      chk("asr_empty", {31'b0, rsp_valid}, 32'd0);

      // Reset mid-operation clears the slot asynchronously.
      set0(1'b1, SH_LSL, 32'h0000_000F, 5'd0);
      #1;
      tick();
      chk("mid_pre_valid", {31'b0, rsp_valid}, 32'd1);
      chk("mid_pre_data", rsp_data, 32'h0000_000F);
      rsp_ready = 1'b0;
      set0(1'b1, SH_LSL, 32'h0000_000F, 5'd4);
      set1(1'b1, SH_LSR, 32'h0000_0100, 5'd8);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mid_rst_data", rsp_data, 32'd0);
      chk("mid_rst_id", {31'b0, rsp_id}, 32'd0);
      chk("mid_rst_ready0", {31'b0, req0_ready}, 32'd0);
      chk("mid_rst_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready0", {31'b0, req0_ready}, 32'd1);
      chk("post_rst_ready1", {31'b0, req1_ready}, 32'd0);
      tick();
      chk("post_rst_valid", {31'b0, rsp_valid}, 32'd1);
      chk("post_rst_id", {31'b0, rsp_id}, 32'd0);
      chk("post_rst_data", rsp_data, 32'h0000_00F0);
      #1;
      chk("post_rst_next_ready1", {31'b0, req1_ready}, 32'd1);
      tick();
      chk("post_rst_next_id", {31'b0, rsp_id}, 32'd1);
      chk("post_rst_next_data", rsp_data, 32'h0000_0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational shift datapath (LSL/LSR/ASR/ROR, 32-bit) between two requesters, e.g. the execute stage (port 0) and the address-generation/helper unit (port 1).
- Round-robin arbitration with valid/ready handshakes on both request ports.
- One registered output slot with valid/ready backpressure.
- Result is available one cycle after acceptance; full throughput of one op per cycle when the consumer is ready.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal log2(DATA_W).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_op  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- req0_data  input  DATA_W  operand.
- req0_shamt  input  SHAMT_W  shift amount.
- req1_valid / req1_ready / req1_op / req1_data / req1_shamt: same as port 0, for requester 1.
- rsp_valid  output  1  output slot holds a result.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_data  output  DATA_W  shifted result.
- rsp_id  output  1  index of the requester that produced rsp_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1, so port 0 wins the first conflict.
  - req0_ready and req1_ready are forced 0 while rst_n is low.
- Slot state is two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational, same cycle):
  - Only one valid request: grant it if can_accept.
  - Both valid: grant the port != last_grant.
  - reqN_ready = can_accept & grantN. At most one ready is high per cycle.
  - A requester must hold valid and its payload stable until ready. The arbiter never grants a port whose valid is low.
- Accept (reqN_valid & reqN_ready at a clock edge):
  - rsp_data <= shift_core(opN, dataN, shamtN).
  - rsp_id <= N, rsp_valid <= 1, last_grant <= N.
- Drain without accept (rsp_valid & rsp_ready, no grant): rsp_valid <= 0. rsp_data and rsp_id hold their old value.
- Simultaneous drain and accept in one cycle: the slot is overwritten with the new result and rsp_valid stays 1 (no bubble).
- FULL with rsp_ready=0: both readies are 0, and rsp_data/rsp_id/rsp_valid are held stable.
- last_grant updates only on an actual accept.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- Arithmetic rules:
  - shamt=0 returns the operand unchanged for every op.
  - LSL/LSR zero-fill.
  - ASR fills with operand bit DATA_W-1 for all shift amounts 1..31.
  - ROR rotates right by shamt.
  - No flags are produced. shamt is never saturated or truncated beyond SHAMT_W.
- A reset asserted mid-operation discards the slot contents immediately. No partial result is ever presented.

Decomposition:
- Package shift_pkg holds:
  - DATA_W and SHAMT_W constants.
  - The 2-bit op type and its encodings SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ROR=2'b11.
- Sub-module shift_core: purely combinational, inputs op/data/shamt, output result.
  - Implemented as a 5-stage log shifter with per-stage fill select (zero, sign, or wrap bits).
  - Instantiated once, fed by a 2:1 payload mux driven by the grant.
- shift_arbiter itself holds the grant logic, last_grant, and the output slot registers.

Test Plan:
- Single ASR: req0 ASR data=0x80000000 shamt=4, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0xF8000000, rsp_id=0; slot empties the cycle after.
- Op corners:
  - LSR 0xDEADBEEF shamt=0 -> 0xDEADBEEF.
  - LSL 0x00000001 shamt=31 -> 0x80000000.
  - ROR 0x00000001 shamt=1 -> 0x80000000.
  - ASR 0x7FFFFFFF shamt=31 -> 0x00000000.
  - ASR 0x80000001 shamt=31 -> 0xFFFFFFFF.
- Fairness: both ports valid continuously with rsp_ready=1 -> grant sequence 0,1,0,1 from reset; one result per cycle, rsp_id alternating; no cycle with both readies high.
- Backpressure: slot FULL and rsp_ready=0 for 3 cycles -> both readies 0, rsp_data/rsp_id unchanged. Then rsp_ready=1 with req1 valid -> drain and accept in the same cycle, rsp_valid stays 1, rsp_id=1.
- Lone requester: only req1 valid for 4 ops, rsp_ready=1 -> req1 is granted every cycle despite last_grant=1.
- Reset mid-operation: rst_n low for 1 cycle while rsp_valid=1 -> rsp_valid=0 and rsp_data=0 asynchronously; after release, a conflict grants port 0 first.
